// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main-control sequencer.
// State enum, opcode constants, ALUOp / ALU B-source encodings and the Moore control decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'd0;
    localparam logic [1:0] ALUOP_SUB  = 2'd1;
    localparam logic [1:0] ALUOP_FUNC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write_cond;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    // Pure Moore decode; ir_write/pc_write are handled separately because they depend on mem_ready.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b0;
                c.alu_src_a = 1'b0;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            DECODE: begin
                c.alu_src_a = 1'b0;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNC;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNC;
            end
            ALU_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RS2;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// Memory-request watchdog: counts unanswered request cycles and pulses expire at TIMEOUT.
// TIMEOUT = 0 disables expiry entirely.
module mc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expire
);

    logic [TW-1:0] cnt;

    // A ready in the same cycle as the terminal count wins over expiry.
    assign expire = (TIMEOUT != 0) && active && !done && (cnt == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!active || done || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I main-control sequencer with memory handshake watchdog.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into HALT and raise a sticky illegal flag.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | read registers, precompute branch target in ALUOut
// EXEC_R   | ALU on rs1, rs2 with funct decode
// EXEC_I   | ALU on rs1, immediate with funct decode
// ALU_WB   | write ALUOut to rd
// MEM_ADDR | compute load/store effective address
// MEM_RD   | load request at ALUOut
// MEM_WB   | write MDR to rd
// MEM_WR   | store request at ALUOut
// BRANCH   | compare rs1 - rs2, load branch target if zero
// HALT     | illegal-opcode trap (only with MC_CTRL_ILLEGAL_TRAP_EN)
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       bus_err,
    output logic       busy
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   expire;
    logic   fetch_entry;

    // zero is consumed by the datapath, gated there by pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    mc_wait_timer #(
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .active(ctrl.mem_req),
        .done  (mem_ready),
        .expire(expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (mem_ready) begin
                    state_nxt = DECODE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:               state_nxt = EXEC_R;
                    OP_I:               state_nxt = EXEC_I;
                    OP_LOAD, OP_STORE:  state_nxt = MEM_ADDR;
                    OP_BRANCH:          state_nxt = BRANCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:            state_nxt = HALT;
`else
                    default:            state_nxt = FETCH;
`endif
                endcase
            end
            EXEC_R:   state_nxt = ALU_WB;
            EXEC_I:   state_nxt = ALU_WB;
            ALU_WB:   state_nxt = FETCH;
            MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready) begin
                    state_nxt = MEM_WB;
                end else if (expire) begin
                    state_nxt = FETCH;
                end
            end
            MEM_WB:   state_nxt = FETCH;
            MEM_WR: begin
                if (mem_ready || expire) begin
                    state_nxt = FETCH;
                end
            end
            BRANCH:   state_nxt = FETCH;
            HALT:     state_nxt = HALT;
            default:  state_nxt = FETCH;
        endcase
    end

    // A watchdog abort from FETCH back into FETCH counts as a fresh fetch.
    assign fetch_entry = (state_nxt == FETCH) && ((state != FETCH) || expire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            ctrl    <= decode_ctrl(FETCH);
            bus_err <= 1'b0;
            busy    <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            ctrl  <= decode_ctrl(state_nxt);
            busy  <= !fetch_entry;
            if (expire) begin
                bus_err <= 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (state_nxt == HALT) begin
                illegal <= 1'b1;
            end
`endif
        end
    end

    assign ir_write      = (state == FETCH) && mem_ready;
    assign pc_write      = (state == FETCH) && mem_ready;
    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign iord          = ctrl.iord;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control vectors queued and compared.
module tb_mc_ctrl_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_ALU_WB = 4,
                   S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WB = 7, S_MEM_WR = 8, S_BRANCH = 9,
                   S_HALT = 10;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, bus_err, busy;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic       z;
        int         st;
        logic       first;
        logic       berr;
    } step_t;

    step_t       stim_q[$];
    logic [15:0] exp_q[$];

    mc_ctrl_fsm #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end

    function automatic logic [15:0] exp_vec(input int st, input logic rdy, input logic berr,
                                            input logic first);
        logic mreq, mwe, io, irw, pcw, pwc, psrc, asa, rw, m2r, bsy;
        logic [1:0] asb, aop;
        {mreq, mwe, io, irw, pcw, pwc, psrc, asa, rw, m2r} = '0;
        asb = 2'd0;
        aop = 2'd0;
        bsy = 1'b1;
        case (st)
            S_FETCH:    begin mreq = 1; asb = 2'd1; irw = rdy; pcw = rdy; bsy = !first; end
            S_DECODE:   asb = 2'd2;
            S_EXEC_R:   begin asa = 1; asb = 2'd0; aop = 2'd2; end
            S_EXEC_I:   begin asa = 1; asb = 2'd2; aop = 2'd2; end
            S_ALU_WB:   rw = 1;
            S_MEM_ADDR: begin asa = 1; asb = 2'd2; end
            S_MEM_RD:   begin mreq = 1; io = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mreq = 1; mwe = 1; io = 1; end
            S_BRANCH:   begin asa = 1; asb = 2'd0; aop = 2'd1; pwc = 1; psrc = 1; end
            default:    ;
        endcase
        return {mreq, mwe, io, irw, pcw, pwc, psrc, asa, asb, aop, rw, m2r, berr, bsy};
    endfunction

    task automatic add(input logic [6:0] op, input logic rdy, input logic z, input int st,
                       input logic first, input logic berr);
        step_t s;
        s.op = op; s.rdy = rdy; s.z = z; s.st = st; s.first = first; s.berr = berr;
        stim_q.push_back(s);
    endtask

    task automatic test_reset;
        logic [15:0] act, e;
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(exp_vec(S_FETCH, 1'b0, 1'b0, 1'b1));
        #1;
        act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL reset got=%b want=%b", act, e);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        add(R, 1, 0, S_FETCH, 1, 0); add(R, 1, 0, S_DECODE, 0, 0);
        add(R, 1, 0, S_EXEC_R, 0, 0); add(R, 1, 0, S_ALU_WB, 0, 0);
        add(I, 1, 0, S_FETCH, 1, 0); add(I, 0, 0, S_DECODE, 0, 0);
        add(I, 0, 0, S_EXEC_I, 0, 0); add(I, 0, 0, S_ALU_WB, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL alu step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_store;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        add(LD, 1, 0, S_FETCH, 1, 0); add(LD, 0, 0, S_DECODE, 0, 0);
        add(LD, 0, 0, S_MEM_ADDR, 0, 0);
        add(LD, 0, 0, S_MEM_RD, 0, 0); add(LD, 0, 0, S_MEM_RD, 0, 0);
        add(LD, 0, 0, S_MEM_RD, 0, 0); add(LD, 1, 0, S_MEM_RD, 0, 0);
        add(LD, 0, 0, S_MEM_WB, 0, 0);
        add(ST, 1, 0, S_FETCH, 1, 0); add(ST, 0, 0, S_DECODE, 0, 0);
        add(ST, 0, 0, S_MEM_ADDR, 0, 0); add(ST, 1, 0, S_MEM_WR, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL load_store step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        add(BR, 1, 1, S_FETCH, 1, 0); add(BR, 0, 1, S_DECODE, 0, 0);
        add(BR, 0, 1, S_BRANCH, 0, 0);
        add(BR, 1, 0, S_FETCH, 1, 0); add(BR, 0, 0, S_DECODE, 0, 0);
        add(BR, 0, 0, S_BRANCH, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL branch step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        add(I, 1, 0, S_FETCH, 1, 0); add(I, 1, 0, S_DECODE, 0, 0);
        add(I, 1, 0, S_EXEC_I, 0, 0); add(I, 1, 0, S_ALU_WB, 0, 0);
        add(ST, 1, 0, S_FETCH, 1, 0); add(ST, 1, 0, S_DECODE, 0, 0);
        add(ST, 1, 0, S_MEM_ADDR, 0, 0); add(ST, 1, 0, S_MEM_WR, 0, 0);
        add(LD, 1, 0, S_FETCH, 1, 0); add(LD, 1, 0, S_DECODE, 0, 0);
        add(LD, 1, 0, S_MEM_ADDR, 0, 0); add(LD, 1, 0, S_MEM_RD, 0, 0);
        add(LD, 1, 0, S_MEM_WB, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL back_to_back step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_write;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        add(ST, 1, 0, S_FETCH, 1, 0); add(ST, 0, 0, S_DECODE, 0, 0);
        add(ST, 0, 0, S_MEM_ADDR, 0, 0); add(ST, 0, 0, S_MEM_WR, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL rst_mid step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1 rst = 1'b1;
        exp_q.push_back(exp_vec(S_FETCH, 1'b0, 1'b0, 1'b1));
        #1;
        act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL rst_mid_async got=%b want=%b", act, e);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        // 17 unanswered request cycles expire; the abort re-enters FETCH with bus_err set.
        for (int k = 1; k <= 17; k++) add(R, 0, 0, S_FETCH, (k == 1), 0);
        add(R, 1, 0, S_FETCH, 1, 1); add(R, 0, 0, S_DECODE, 0, 1);
        add(R, 0, 0, S_EXEC_R, 0, 1); add(R, 0, 0, S_ALU_WB, 0, 1);
        add(R, 0, 0, S_FETCH, 1, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL timeout step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout_race;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        for (int k = 1; k <= 16; k++) add(R, 0, 0, S_FETCH, (k == 1), 0);
        add(R, 1, 0, S_FETCH, 0, 0); add(R, 0, 0, S_DECODE, 0, 0);
        add(R, 0, 0, S_EXEC_R, 0, 0); add(R, 0, 0, S_ALU_WB, 0, 0);
        add(LD, 1, 0, S_FETCH, 1, 0); add(LD, 0, 0, S_DECODE, 0, 0);
        add(LD, 0, 0, S_MEM_ADDR, 0, 0);
        for (int k = 1; k <= 16; k++) add(LD, 0, 0, S_MEM_RD, 0, 0);
        add(LD, 1, 0, S_MEM_RD, 0, 0); add(LD, 0, 0, S_MEM_WB, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL timeout_race step%0d got=%b want=%b", n, act, e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_unknown_opcode;
        logic [15:0] act, e;
        step_t s;
        int n = 0;
        add(BAD, 1, 0, S_FETCH, 1, 0); add(BAD, 0, 0, S_DECODE, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        add(BAD, 1, 0, S_HALT, 0, 0); add(BAD, 1, 0, S_HALT, 0, 0);
`else
        add(BAD, 0, 0, S_FETCH, 1, 0); add(BAD, 0, 0, S_FETCH, 0, 0);
`endif
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            exp_q.push_back(exp_vec(s.st, s.rdy, s.berr, s.first));
            #1;
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, busy};
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL unknown_op step%0d got=%b want=%b", n, act, e);
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            total++;
            if (illegal !== (n >= 2)) begin
                bad++;
                $display("FAIL illegal step%0d got=%b want=%b", n, illegal, (n >= 2));
            end
`endif
            n++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_rst_mid_write();
        test_timeout();
        test_timeout_race();
        test_unknown_opcode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle main-control sequencer for the RV32I core.
- Steps one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the shared ALU's ALUOp (decoded further by the ALU control decoder), register file, PC and IR enables, and a single shared memory port.
- Owns the memory request/ready handshake and a timeout watchdog on it.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready before flagging a bus error; 0 disables the watchdog.
- TW, 5, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  write enable for the request (store).
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = immediate.
- alu_op  out  2  0 = add, 1 = sub, 2 = use funct fields.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  writeback from MDR instead of ALUOut.
- bus_err  out  1  sticky; set on watchdog expiry.
- busy  out  1  high in every state except FETCH on its first cycle.

Behaviour:
- Reset: state = FETCH; wait counter = 0; bus_err = 0; all other outputs follow the FETCH decode below.
- Outputs are a Moore decode of state; no output depends combinationally on opcode or mem_ready.
- Unlisted outputs are 0 in every state.

States and transitions:
- FETCH
  - Outputs: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0.
  - When mem_ready: ir_write and pc_write pulse for that cycle only (qualified by mem_ready; this is the only Mealy term), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - Outputs: alu_src_a = 0, alu_src_b = 2, alu_op = 0 (precompute branch target).
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - anything else → FETCH (NOP).
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 2 → ALU_WB.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = 2 → ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0 → FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0.
  - Load → MEM_RD; store → MEM_WR.
- MEM_RD: mem_req = 1, iord = 1; on mem_ready → MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1 → FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, iord = 1; on mem_ready → FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_write_cond = 1, pc_src = 1 → FETCH.

Latencies with zero-wait memory:
- R/I: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.

Watchdog:
- Counter increments each cycle mem_req = 1 and mem_ready = 0; clears on mem_ready or on leaving a memory state.
- When the counter reaches TIMEOUT: bus_err is set, the request is abandoned, and the FSM goes to FETCH with the counter cleared.
- bus_err clears only on rst.
- mem_ready and timeout in the same cycle: mem_ready wins and bus_err is not set.

Reset mid-operation:
- Returns to FETCH immediately (asynchronously).
- mem_req follows the FETCH decode; any in-flight transaction is dropped.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal (1 bit, sticky until rst).
  - An unknown opcode in DECODE goes to state HALT: all enables 0, mem_req 0, busy 1, illegal = 1. HALT exits only on rst.
- Undefined:
  - Unknown opcodes return to FETCH as NOP.
  - No illegal port exists.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum;
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp encodings ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC;
  - alu_src_b encodings.
- One sub-module, mc_wait_timer: counter, compare against TIMEOUT, expiry pulse.
- The FSM and output decode stay in mc_ctrl_fsm.

Test Plan:
- R-type 0110011, mem_ready tied 1 → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write = 1 on cycle 4 with alu_op = 2 on cycle 3; back in FETCH on cycle 5.
- Load 0000011, mem_ready delayed 3 cycles in MEM_RD → mem_req and iord held high 4 cycles; MEM_WB asserts reg_write = 1 and mem_to_reg = 1 once.
- Store 0100011 → exactly one cycle with mem_req = 1, mem_we = 1 and mem_ready = 1; reg_write never asserted.
- Branch with zero = 1 and then zero = 0 → pc_write_cond = 1, pc_src = 1, alu_op = 1 in BRANCH for both; the PC changes only when zero = 1 (checked in datapath harness).
- TIMEOUT = 16, mem_ready held 0 in FETCH → bus_err rises on the 17th request cycle and the FSM re-enters FETCH; a separate case with mem_ready arriving in the expiry cycle → bus_err stays 0.
- rst pulsed during MEM_WR → next edge shows FETCH with mem_we = 0; unknown opcode 1111111 → FETCH when the macro is undefined, HALT with illegal = 1 when defined.
